pool_window_ctrl: RTL

- Sequencer for the pooling line buffer in the CNN core.
- Accepts a raster-order pixel stream for one IX x IY feature map and generates the line-buffer write controls: write enable, column address and row select.
- Tracks the column/row counters and emits a registered window-valid event, with the pooled output coordinates, each time a KxK stride-K window is complete.
- Applies backpressure upstream while a window is waiting on the downstream pooling unit, and signals frame completion.

---
 rtl/pool_window_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pool_window_ctrl.sv
// Pooling line-buffer sequencer.
// Takes one raster-order IX x IY feature map and produces line-buffer write
// controls. After each complete KxK, stride-K window it raises a registered
// window event that carries the pooled coordinates.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_start; no pixels are accepted
// ST_RUN   | accepting pixels; stalls while a window waits downstream
// ST_FLUSH | last pixel taken; waiting for the final window to drain
module pool_window_ctrl #(
  parameter int IX = 32,
  parameter int IY = 32,
  parameter int K  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  output logic                      o_lb_wr_en,
  output logic [$clog2(IX)-1:0]     o_lb_wr_addr,
  output logic [$clog2(K)-1:0]      o_lb_row_sel,
  output logic                      o_win_valid,
  input  logic                      i_out_ready,
  output logic [$clog2(IX/K)-1:0]   o_win_x,
  output logic [$clog2(IY/K)-1:0]   o_win_y,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  localparam int XW  = $clog2(IX);
  localparam int YW  = $clog2(IY);
  localparam int KW  = $clog2(K);
  localparam int WXW = $clog2(IX/K);
  localparam int WYW = $clog2(IY/K);

  localparam logic [XW-1:0] X_LAST = XW'(IX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IY - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  // kx/ky are the position inside the window, and wx/wy are the window index
  // of the current pixel. Keeping them as separate counters avoids a mod and
  // a divide by K on the pixel counters.
  logic [KW-1:0]  kx_q, kx_d;
  logic [KW-1:0]  ky_q, ky_d;
  logic [WXW-1:0] wx_q, wx_d;
  logic [WYW-1:0] wy_q, wy_d;
  logic           win_valid_q, win_valid_d;
  logic [WXW-1:0] win_x_q, win_x_d;
  logic [WYW-1:0] win_y_q, win_y_d;
  logic           done_q, done_d;

  logic in_ready, acc, fire, consume;
  logic x_last, y_last, kx_last, ky_last;

  // Handshake and window-completion decode
  always_comb begin
    in_ready = (state_q == ST_RUN) && !(win_valid_q && !i_out_ready);
    acc      = i_in_valid && in_ready;
    x_last   = (x_q == X_LAST);
    y_last   = (y_q == Y_LAST);
    kx_last  = (kx_q == K_LAST);
    ky_last  = (ky_q == K_LAST);
    fire     = acc && kx_last && ky_last;
    consume  = win_valid_q && i_out_ready;
  end

  // Next-state: FSM, pixel/window counters and the pending-window register
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    wx_d        = wx_q;
    wy_d        = wy_q;
    win_valid_d = win_valid_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          x_d     = '0;
          y_d     = '0;
          kx_d    = '0;
          ky_d    = '0;
          wx_d    = '0;
          wy_d    = '0;
        end
      end
      ST_RUN: begin
        if (acc) begin
          if (x_last) begin
            x_d  = '0;
            kx_d = '0;
            wx_d = '0;
            if (y_last) begin
              y_d     = '0;
              ky_d    = '0;
              wy_d    = '0;
              state_d = ST_FLUSH;
            end else begin
              y_d  = y_q + 1'b1;
              ky_d = ky_last ? '0 : ky_q + 1'b1;
              wy_d = ky_last ? wy_q + 1'b1 : wy_q;
            end
          end else begin
            x_d  = x_q + 1'b1;
            kx_d = kx_last ? '0 : kx_q + 1'b1;
            wx_d = kx_last ? wx_q + 1'b1 : wx_q;
          end
        end
      end
      ST_FLUSH: begin
        if (!win_valid_q || i_out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fire overrides a same-cycle consume, so the new window follows the
    // old one with no gap.
    if (fire) begin
      win_valid_d = 1'b1;
      win_x_d     = wx_q;
      win_y_d     = wy_q;
    end else if (consume) begin
      win_valid_d = 1'b0;
    end
  end

  // State registers; asynchronous reset drops any pending window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      wx_q        <= '0;
      wy_q        <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      done_q      <= done_d;
    end
  end

  // Output drive
  always_comb begin
    o_in_ready   = in_ready;
    o_lb_wr_en   = acc;
    o_lb_wr_addr = x_q;
    o_lb_row_sel = ky_q;
    o_win_valid  = win_valid_q;
    o_win_x      = win_x_q;
    o_win_y      = win_y_q;
    o_busy       = (state_q == ST_RUN);
    o_frame_done = done_q;
  end

endmodule
